// File: rtl/bm_dag_sched_if.sv
// bm_dag_sched_if
//   Bundles the requester, shared-datapath and response signals of
//   bm_dag_sched. The scheduler connects through the slave modport. The
//   environment (requesters plus datapath) connects through the master
//   modport.
//   enable    : issue enable; low blocks new grants only
//   req       : per-requester level request
//   req_a/b   : packed operands, requester i at [i*BITS +: BITS]
//   gnt       : one-hot combinational grant
//   dp_valid  : registered issue strobe to the datapath
//   dp_a/dp_b : registered operands of the granted requester
//   dp_res    : datapath result, LAT cycles after dp_valid
//   rsp_valid : registered one-hot response strobe
//   rsp_data  : registered result, qualified by rsp_valid
//   busy      : any issue in flight
interface bm_dag_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned BITS = 2
);
  logic                 enable;
  logic [NREQ-1:0]      req;
  logic [NREQ*BITS-1:0] req_a;
  logic [NREQ*BITS-1:0] req_b;
  logic [NREQ-1:0]      gnt;
  logic                 dp_valid;
  logic [BITS-1:0]      dp_a;
  logic [BITS-1:0]      dp_b;
  logic [BITS-1:0]      dp_res;
  logic [NREQ-1:0]      rsp_valid;
  logic [BITS-1:0]      rsp_data;
  logic                 busy;

  modport master (
    output enable, req, req_a, req_b, dp_res,
    input  gnt, dp_valid, dp_a, dp_b, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  enable, req, req_a, req_b, dp_res,
    output gnt, dp_valid, dp_a, dp_b, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/bm_dag_sched.sv
// bm_dag_sched
//   Round-robin issue scheduler in front of a shared fixed-latency datapath.
//   A grant registers the winner's operands onto dp_a/dp_b with dp_valid. A
//   LAT-stage {valid, index} tag pipeline follows each issue. The result is
//   sampled from dp_res when the tag reaches the last stage and is returned
//   one cycle later on rsp_valid/rsp_data. Responses come back in issue
//   order.
//   Ports: clock, reset_n (async, active-low), bus (bm_dag_sched_if.slave).
//   Parameters: NREQ requesters, BITS operand/result width, LAT datapath
//   latency (1..8).
//   Macro BM_DAG_SCHED_PRIO_EN: when defined, req[0] has absolute priority.
//   The other requesters are then arbitrated round-robin among themselves,
//   and index-0 grants leave last_grant unchanged.
module bm_dag_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned BITS = 2,
  parameter int unsigned LAT  = 4
) (
  input logic           clock,
  input logic           reset_n,
  bm_dag_sched_if.slave bus
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  logic [IW-1:0]          last_q, last_d;
  logic                   dp_valid_q, dp_valid_d;
  logic [BITS-1:0]        dp_a_q, dp_a_d;
  logic [BITS-1:0]        dp_b_q, dp_b_d;
  logic [IW-1:0]          dp_idx_q, dp_idx_d;
  logic [LAT-1:0]         tag_v_q, tag_v_d;
  logic [LAT-1:0][IW-1:0] tag_idx_q, tag_idx_d;
  logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [BITS-1:0]        rsp_data_q, rsp_data_d;

  logic [NREQ-1:0]        gnt_c;
  logic [IW-1:0]          win;
  logic                   win_v;
  logic                   grant;

  // Winner search starting at last_grant+1, wrapping modulo NREQ.
  always_comb begin
    logic [IW-1:0] j;
    win   = '0;
    win_v = 1'b0;
    j     = '0;
`ifdef BM_DAG_SCHED_PRIO_EN
    if (bus.req[0]) begin
      win_v = 1'b1;
    end
`endif
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j = IW'((32'(last_q) + k) % NREQ);
`ifdef BM_DAG_SCHED_PRIO_EN
      if (!win_v && j != '0 && bus.req[j]) begin
`else
      if (!win_v && bus.req[j]) begin
`endif
        win   = j;
        win_v = 1'b1;
      end
    end
    gnt_c = '0;
    // Reset forces the grant low as well as clearing the flops.
    if (win_v && bus.enable && reset_n) begin
      gnt_c[win] = 1'b1;
    end
    grant = |gnt_c;
  end

  always_comb begin
    last_d = last_q;
`ifdef BM_DAG_SCHED_PRIO_EN
    if (grant && win != '0) begin
      last_d = win;
    end
`else
    if (grant) begin
      last_d = win;
    end
`endif

    dp_valid_d = grant;
    dp_a_d     = dp_a_q;
    dp_b_d     = dp_b_q;
    dp_idx_d   = dp_idx_q;
    if (grant) begin
      dp_idx_d = win;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (gnt_c[i]) begin
          dp_a_d = bus.req_a[i*BITS +: BITS];
          dp_b_d = bus.req_b[i*BITS +: BITS];
        end
      end
    end

    // The tag follows dp_valid by one stage, so it reaches the last stage in
    // the cycle where dp_res is valid for that issue.
    tag_v_d      = '0;
    tag_idx_d    = '0;
    tag_v_d[0]   = dp_valid_q;
    tag_idx_d[0] = dp_idx_q;
    for (int unsigned i = 1; i < LAT; i++) begin
      tag_v_d[i]   = tag_v_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end

    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_v_q[LAT-1]) begin
      rsp_valid_d[tag_idx_q[LAT-1]] = 1'b1;
      rsp_data_d                    = bus.dp_res;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q      <= LAST_RST;
      dp_valid_q  <= 1'b0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      dp_idx_q    <= '0;
      tag_v_q     <= '0;
      tag_idx_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      last_q      <= last_d;
      dp_valid_q  <= dp_valid_d;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      dp_idx_q    <= dp_idx_d;
      tag_v_q     <= tag_v_d;
      tag_idx_q   <= tag_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.dp_valid  = dp_valid_q;
  assign bus.dp_a      = dp_a_q;
  assign bus.dp_b      = dp_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = dp_valid_q | (|tag_v_q);
endmodule

// File: tb/tb_bm_dag_sched.sv
// tb_bm_dag_sched
//   Self-checking bench for bm_dag_sched. A behavioural model keeps
//   per-cycle expectation tables: operands due on dp_a/dp_b, the dp_res
//   value to drive, the response due, and the busy window. The tables are
//   filled from the round-robin rule whenever the model predicts a grant.
//   One negedge process compares every DUT output against the tables.
//   Directed literal checks pin the model's behaviour. Randomized traffic
//   with occasional resets follows.
module tb_bm_dag_sched;
  localparam int unsigned NREQ = 4;
  localparam int unsigned BITS = 2;
  localparam int unsigned LAT  = 4;

  logic clock;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  bm_dag_sched_if #(.NREQ(NREQ), .BITS(BITS)) bus ();

  bm_dag_sched #(.NREQ(NREQ), .BITS(BITS), .LAT(LAT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Model state
  int              m_last = NREQ - 1;
  int              busy_until = -1;
  logic [BITS-1:0] cur_a = '0, cur_b = '0, cur_rd = '0;
  logic [BITS-1:0] e_dpa [int];
  logic [BITS-1:0] e_dpb [int];
  logic [BITS-1:0] e_rd  [int];
  int              e_ri  [int];
  logic [BITS-1:0] sched [int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [BITS-1:0] dp_fn(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    logic [BITS-1:0] r;
    r = a + b;
    return r;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    int j;
`ifdef BM_DAG_SCHED_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      j = (last + k) % NREQ;
`ifdef BM_DAG_SCHED_PRIO_EN
      if (j == 0) continue;
`endif
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // The datapath: drives the modelled result in the cycle it is due, and
  // random junk otherwise.
  always begin
    @(posedge clock);
    #1;
    if (sched.exists(cyc)) bus.dp_res = sched[cyc];
    else bus.dp_res = BITS'($urandom);
  end

  // Compare process
  always @(negedge clock) begin
    int g;
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] ers;
    logic [BITS-1:0] a, b;
    if (!reset_n) begin
      e_dpa.delete(); e_dpb.delete(); e_rd.delete(); e_ri.delete(); sched.delete();
      m_last = NREQ - 1; busy_until = -1;
      cur_a = '0; cur_b = '0; cur_rd = '0;
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_dp_valid", 32'(bus.dp_valid), 0);
      chk("rst_dp_a", 32'(bus.dp_a), 0);
      chk("rst_dp_b", 32'(bus.dp_b), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 0);
      chk("rst_busy", 32'(bus.busy), 0);
    end else begin
      g  = bus.enable ? pick(bus.req, m_last) : -1;
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      chk("gnt", 32'(bus.gnt), 32'(eg));
      if (e_dpa.exists(cyc)) begin
        cur_a = e_dpa[cyc]; cur_b = e_dpb[cyc];
        chk("dp_valid", 32'(bus.dp_valid), 1);
      end else begin
        chk("dp_valid", 32'(bus.dp_valid), 0);
      end
      chk("dp_a", 32'(bus.dp_a), 32'(cur_a));
      chk("dp_b", 32'(bus.dp_b), 32'(cur_b));
      ers = '0;
      if (e_ri.exists(cyc)) begin
        ers[e_ri[cyc]] = 1'b1;
        cur_rd = e_rd[cyc];
      end
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(ers));
      chk("rsp_data", 32'(bus.rsp_data), 32'(cur_rd));
      chk("busy", 32'(bus.busy), (cyc <= busy_until) ? 1 : 0);
      if (g >= 0) begin
        a = bus.req_a[g*BITS +: BITS];
        b = bus.req_b[g*BITS +: BITS];
        e_dpa[cyc+1] = a;
        e_dpb[cyc+1] = b;
        sched[cyc+1+LAT] = dp_fn(a, b);
        e_ri[cyc+LAT+2] = g;
        e_rd[cyc+LAT+2] = dp_fn(a, b);
        busy_until = cyc + LAT + 1;
`ifdef BM_DAG_SCHED_PRIO_EN
        if (g != 0) m_last = g;
`else
        m_last = g;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    bus.enable = 1'b0; bus.req = '0; bus.req_a = '0; bus.req_b = '0; bus.dp_res = '0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Arbitration sequence straight out of reset
    bus.req_a = (NREQ*BITS)'($urandom); bus.req_b = (NREQ*BITS)'($urandom);
    bus.enable = 1'b1;
`ifndef BM_DAG_SCHED_PRIO_EN
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("rr_seq", 32'(bus.gnt), 32'(1 << (k % 4)));
      if (k > 0) chk("rr_dp_valid", 32'(bus.dp_valid), 1);
    end
`else
    bus.req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("prio_gnt0", 32'(bus.gnt), 32'h1);
    end
    tick();
    bus.req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("prio_alt", 32'(bus.gnt), (k % 2 == 0) ? 32'h2 : 32'h8);
    end
`endif
    tick(); bus.req = '0;
    repeat (LAT + 4) tick();

    // Single issue from requester 2, response latency LAT+2
    bus.req_a = 8'b0010_0000; bus.req_b = 8'b0001_0000; bus.req = 4'b0100;
    @(negedge clock);
    chk("lat_gnt", 32'(bus.gnt), 32'h4);
    tick(); bus.req = '0;
    repeat (5) @(negedge clock);
    chk("lat_early", 32'(bus.rsp_valid), 0);
    @(negedge clock);
    chk("lat_rsp_valid", 32'(bus.rsp_valid), 32'h4);
    chk("lat_rsp_data", 32'(bus.rsp_data), 32'h3);
    repeat (LAT + 2) tick();

    // Three back-to-back issues from requester 1
    bus.req = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      bus.req_a = (NREQ*BITS)'($urandom); bus.req_b = (NREQ*BITS)'($urandom);
      @(negedge clock);
      chk("b2b_gnt", 32'(bus.gnt), 32'h2);
      tick();
    end
    bus.req = '0;
    repeat (LAT) @(negedge clock);
    chk("b2b_rsp", 32'(bus.rsp_valid), 32'h2);
    repeat (2) begin
      @(negedge clock);
      chk("b2b_rsp", 32'(bus.rsp_valid), 32'h2);
    end
    repeat (LAT + 2) tick();

    // Enable drops after two grants; in-flight issues drain
    bus.req = 4'b1111;
    repeat (2) @(negedge clock);
    tick(); bus.enable = 1'b0;
    @(negedge clock);
    chk("en_gnt0", 32'(bus.gnt), 0);
    chk("en_dpv_last", 32'(bus.dp_valid), 1);
    @(negedge clock);
    chk("en_dpv_off", 32'(bus.dp_valid), 0);
    repeat (LAT + 4) tick();
    bus.req = '0; bus.enable = 1'b1;
    tick();

    // Reset with three issues outstanding
    bus.req = 4'b1111;
    repeat (3) @(negedge clock);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(bus.gnt), 0);
    chk("mid_rst_dpv", 32'(bus.dp_valid), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_rspv", 32'(bus.rsp_valid), 0);
    chk("mid_rst_dpa", 32'(bus.dp_a), 0);
    chk("mid_rst_rspd", 32'(bus.rsp_data), 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_first", 32'(bus.gnt), 32'h1);
    tick(); bus.req = '0;
    repeat (LAT + 4) tick();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      tick();
      reset_n    = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      bus.req    = NREQ'($urandom);
      bus.enable = ($urandom_range(0, 7) != 0);
      bus.req_a  = (NREQ*BITS)'($urandom);
      bus.req_b  = (NREQ*BITS)'($urandom);
    end
    tick();
    reset_n = 1'b1; bus.req = '0;
    repeat (LAT + 4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
